// File: rtl/vec_exec_pkg.sv
// Shared encodings for the vector execute sequencer and its lane ALUs.
package vec_exec_pkg;

    typedef enum logic [1:0] {
        OP_SCA = 2'b00,
        OP_VV  = 2'b01,
        OP_VS  = 2'b10,
        OP_RSV = 2'b11
    } optype_e;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } aluctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// One combinational L-bit lane: unsigned add/sub (wrapping or saturating), and, or.
import vec_exec_pkg::*;

module vec_lane_alu #(
    parameter int unsigned L = 8
) (
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    input  logic [1:0]   alu_ctrl,
    input  logic         sat,
    output logic [L-1:0] y
);

    logic [L:0] sum;
    logic [L:0] diff;

    // The extra MSB is the carry out for add and the borrow for sub.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y = '0;
        case (aluctrl_e'(alu_ctrl))
            ADD:     y = (sat && sum[L])  ? '1 : sum[L-1:0];
            SUB:     y = (sat && diff[L]) ? '0 : diff[L-1:0];
            AND:     y = a & b;
            OR:      y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vector_exec_sequencer.sv
// Multi-beat vector execute unit: P lane ALUs sweep an I-element vector, P elements per beat.
import vec_exec_pkg::*;

module vector_exec_sequencer #(
    parameter  int unsigned L  = 8,
    parameter  int unsigned I  = 20,
    parameter  int unsigned P  = 4,
    localparam int unsigned NB = (I + P - 1) / P,
    localparam int unsigned BW = $clog2(NB) + 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start_i,
    output logic            ready_o,
    input  logic [1:0]      op_type_i,
    input  logic [1:0]      alu_ctrl_i,
    input  logic            sat_i,
    input  logic [I*L-1:0]  vec_a_i,
    input  logic [I*L-1:0]  vec_b_i,
    input  logic [L-1:0]    scalar_i,
    input  logic            hold_i,
    output logic            busy_o,
    output logic [BW-1:0]   beat_o,
    output logic [I*L-1:0]  result_o,
    output logic            zero_o,
    output logic            done_o
);

    localparam int unsigned NE = NB * P;

    seq_state_e      state_q;
    logic [BW-1:0]   beat_q;
    logic [I*L-1:0]  a_q;
    logic [I*L-1:0]  b_q;
    logic [1:0]      ctrl_q;
    logic            sat_q;
    logic [I*L-1:0]  result_q;
    logic            zero_q;

    logic [NE*L-1:0] a_pad;
    logic [NE*L-1:0] b_pad;
    logic [L-1:0]    lane_a [P];
    logic [L-1:0]    lane_b [P];
    logic [L-1:0]    lane_y [P];
    logic [I*L-1:0]  res_next;
    logic            run_adv;
    logic            start_ok;

    assign run_adv  = (state_q == RUN) && !hold_i;
    assign start_ok = start_i && ((op_type_i == OP_VV) || (op_type_i == OP_VS));

    // Operands are zero-padded to a whole number of beats so tail lanes never index past I.
    always_comb begin
        a_pad = '0;
        b_pad = '0;
        a_pad[I*L-1:0] = a_q;
        b_pad[I*L-1:0] = b_q;
    end

    always_comb begin
        for (int unsigned k = 0; k < P; k++) begin
            lane_a[k] = '0;
            lane_b[k] = '0;
        end
        for (int unsigned bt = 0; bt < NB; bt++) begin
            if (beat_q == BW'(bt)) begin
                for (int unsigned k = 0; k < P; k++) begin
                    lane_a[k] = a_pad[(bt*P + k)*L +: L];
                    lane_b[k] = b_pad[(bt*P + k)*L +: L];
                end
            end
        end
    end

    for (genvar k = 0; k < P; k++) begin : g_lane
        vec_lane_alu #(.L(L)) u_alu (
            .a        (lane_a[k]),
            .b        (lane_b[k]),
            .alu_ctrl (ctrl_q),
            .sat      (sat_q),
            .y        (lane_y[k])
        );
    end

    // Only real elements exist here, so the masked tail lanes of the last beat have no target.
    for (genvar i = 0; i < I; i++) begin : g_elem
        assign res_next[i*L +: L] = (run_adv && (beat_q == BW'(i / P))) ? lane_y[i % P]
                                                                        : result_q[i*L +: L];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            sat_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        a_q     <= vec_a_i;
                        b_q     <= (op_type_i == OP_VS) ? {I{scalar_i}} : vec_b_i;
                        ctrl_q  <= alu_ctrl_i;
                        sat_q   <= sat_i;
                        beat_q  <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!hold_i) begin
                        result_q <= res_next;
                        if (beat_q == BW'(NB - 1)) begin
                            zero_q  <= (res_next == '0);
                            state_q <= DONE;
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = (state_q == RUN);
    assign done_o   = (state_q == DONE);
    assign beat_o   = beat_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// Directed bench for vector_exec_sequencer: a 20-element and an 18-element instance share control inputs.
module tb_vector_exec_sequencer;

    localparam int L  = 8;
    localparam int I  = 20;
    localparam int I2 = 18;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                start, sat, hold;
    logic [1:0]          op, ctrl;
    logic [L-1:0]        sc;
    logic [I-1:0][L-1:0] va, vb, res;
    logic [I2-1:0][L-1:0] res2;
    logic                ready, busy, zero, done;
    logic                ready2, busy2, zero2, done2;
    logic [3:0]          beat, beat2;

    int total = 0;
    int bad   = 0;

    vector_exec_sequencer #(.L(L), .I(I), .P(4)) dut (
        .CLK(clk), .RST(rst_n), .start_i(start), .ready_o(ready),
        .op_type_i(op), .alu_ctrl_i(ctrl), .sat_i(sat),
        .vec_a_i(va), .vec_b_i(vb), .scalar_i(sc), .hold_i(hold),
        .busy_o(busy), .beat_o(beat), .result_o(res), .zero_o(zero), .done_o(done)
    );

    vector_exec_sequencer #(.L(L), .I(I2), .P(4)) dut2 (
        .CLK(clk), .RST(rst_n), .start_i(start), .ready_o(ready2),
        .op_type_i(op), .alu_ctrl_i(ctrl), .sat_i(sat),
        .vec_a_i(va[I2-1:0]), .vec_b_i(vb[I2-1:0]), .scalar_i(sc), .hold_i(hold),
        .busy_o(busy2), .beat_o(beat2), .result_o(res2), .zero_o(zero2), .done_o(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] v);
        for (int e = 0; e < I; e++) chk($sformatf("%s[%0d]", tag, e), res[e], v);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [1:0] c, input logic s);
        op = o; ctrl = c; sat = s; start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) step();
        chk("done_seen", done, 1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; ctrl = 2'b00; sat = 1'b0;
        hold = 1'b0; sc = '0; va = '0; vb = '0;
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_zero", zero, 0);
        chk("rst_beat", beat, 0);
        chk_all("rst_res", 8'h00);
        rst_n = 1'b1;
        step();

        // Vector-vector add with a start attempt mid-run that must be ignored.
        for (int e = 0; e < I; e++) begin va[e] = 8'(e); vb[e] = 8'(2*e); end
        op = 2'b01; ctrl = 2'b00; sat = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("vv_busy", busy, 1);
        chk("vv_ready", ready, 0);
        chk("vv_beat0", beat, 0);
        for (int n = 1; n <= 6; n++) begin
            if (n == 2) begin start = 1'b1; va = '1; end
            step();
            start = 1'b0;
            chk($sformatf("vv_done_e%0d", n), done, (n == 5));
            if (n < 5) chk($sformatf("vv_beat_e%0d", n), beat, n);
        end
        chk("vv_ready_after", ready, 1);
        for (int e = 0; e < I; e++) chk($sformatf("vv_res[%0d]", e), res[e], 3*e);
        chk("vv_zero", zero, 0);

        // Scalar broadcast, saturating then wrapping.
        va = '0; vb = '0;
        for (int e = 0; e < I; e++) begin va[e] = 8'd250; vb[e] = 8'h77; end
        sc = 8'd10;
        run_op(2'b10, 2'b00, 1'b1);
        chk_all("vs_sat", 8'd255);
        run_op(2'b10, 2'b00, 1'b0);
        chk_all("vs_wrap", 8'd4);

        // Subtract with borrow: clamps to zero or wraps.
        for (int e = 0; e < I; e++) begin va[e] = 8'd5; vb[e] = 8'd9; end
        run_op(2'b01, 2'b01, 1'b1);
        chk_all("sub_sat", 8'd0);
        chk("sub_sat_zero", zero, 1);
        run_op(2'b01, 2'b01, 1'b0);
        chk_all("sub_wrap", 8'd252);
        chk("sub_wrap_zero", zero, 0);

        // Logic ops ignore sat.
        for (int e = 0; e < I; e++) begin va[e] = 8'hCC; vb[e] = 8'h0F; end
        run_op(2'b01, 2'b10, 1'b0);
        chk_all("and", 8'h0C);
        run_op(2'b01, 2'b11, 1'b1);
        chk_all("or", 8'hCF);

        // Hold for three cycles during beat 2; the 18-element instance exercises the tail mask.
        for (int e = 0; e < I; e++) begin va[e] = 8'(e + 1); vb[e] = 8'd1; end
        op = 2'b01; ctrl = 2'b00; sat = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("hold_beat_pre", beat, 2);
        hold = 1'b1;
        for (int h = 1; h <= 3; h++) begin
            step();
            chk($sformatf("hold_beat_h%0d", h), beat, 2);
            chk($sformatf("hold_beat2_h%0d", h), beat2, 2);
            chk($sformatf("hold_done_h%0d", h), done, 0);
            chk($sformatf("hold_busy_h%0d", h), busy, 1);
            chk($sformatf("hold_res8_h%0d", h), res[8], 8'hCF);
            chk($sformatf("hold_res2_8_h%0d", h), res2[8], 8'hCF);
        end
        hold = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk($sformatf("hold_done_r%0d", n), done, (n == 3));
            chk($sformatf("hold_done2_r%0d", n), done2, (n == 3));
        end
        for (int e = 0; e < I; e++) chk($sformatf("hold_res[%0d]", e), res[e], e + 2);
        for (int e = 0; e < I2; e++) chk($sformatf("mask_res2[%0d]", e), res2[e], e + 2);
        chk("mask_zero2", zero2, 0);

        // Illegal op types are not accepted.
        op = 2'b00; start = 1'b1;
        step();
        chk("ill00_ready", ready, 1);
        chk("ill00_busy", busy, 0);
        op = 2'b11;
        step();
        chk("ill11_ready", ready, 1);
        chk("ill11_busy", busy, 0);
        start = 1'b0;

        // Asynchronous reset during beat 3.
        op = 2'b01; ctrl = 2'b00; sat = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("arst_beat_pre", beat, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_beat", beat, 0);
        chk("arst_zero", zero, 0);
        chk_all("arst_res", 8'h00);
        step(); step();
        #2 rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            chk($sformatf("arst_nodone_%0d", n), done, 0);
        end
        chk("arst_idle", ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
